pixel_fetcher: RTL

PIXEL_FETCHER -- requirements
Module: pixel_fetcher

---
 rtl/pixel_fetcher_pkg.sv | 24 ++
 rtl/pixel_fetcher_tile_shifter.sv | 41 ++++
 rtl/pixel_fetcher.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pixel_fetcher_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pixel_fetcher_pkg : state type and constants shared by the BG pixel fetcher
// Revision: 1.0
// -----------------------------------------------------------------------------
package pixel_fetcher_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MAP_REQ   = 3'd1,
    LO_REQ    = 3'd2,
    HI_REQ    = 3'd3,
    PUSH_WAIT = 3'd4,
    PUSH      = 3'd5
  } fetch_state_e;

  localparam logic [12:0] MAP_BASE_0     = 13'h1800;
  localparam logic [12:0] MAP_BASE_1     = 13'h1C00;
  localparam logic [12:0] SIGNED_BASE    = 13'h1000;
  localparam int          TILES_PER_LINE = 21;
  localparam int          PIXEL_W        = 6;

endpackage
`default_nettype wire

// File: rtl/pixel_fetcher_tile_shifter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tile_shifter : holds one tile row (lo/hi planes + attr), emits pixels MSB first
// Revision: 1.0
// -----------------------------------------------------------------------------
module tile_shifter
  import pixel_fetcher_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [7:0]         i_lo,
  input  logic [7:0]         i_hi,
  input  logic [3:0]         i_attr,
  input  logic               i_shift,
  output logic [PIXEL_W-1:0] o_pixel
);

  logic [7:0] r_lo;
  logic [7:0] r_hi;
  logic [3:0] r_attr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_attr <= '0;
    end else if (i_load) begin
      r_lo   <= i_lo;
      r_hi   <= i_hi;
      r_attr <= i_attr;
    end else if (i_shift) begin
      r_lo <= {r_lo[6:0], 1'b0};
      r_hi <= {r_hi[6:0], 1'b0};
    end
  end

  assign o_pixel = {r_attr, r_hi[7], r_lo[7]};

endmodule
`default_nettype wire

// File: rtl/pixel_fetcher.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pixel_fetcher : fetches 21 background tiles per scanline and pushes 168 pixels
// Revision: 1.0
// -----------------------------------------------------------------------------
module pixel_fetcher
  import pixel_fetcher_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [7:0]         line_in,
  input  logic [7:0]         scx_in,
  input  logic [7:0]         scy_in,
  input  logic               map_sel_in,
  input  logic               data_sel_in,
  input  logic [3:0]         attr_in,
  output logic               vram_req_out,
  output logic [12:0]        vram_addr_out,
  input  logic               vram_ack_in,
  input  logic [7:0]         vram_data_in,
  input  logic [4:0]         fifo_count_in,
  output logic               fifo_wr_en_out,
  output logic [PIXEL_W-1:0] fifo_pixel_out,
  output logic               busy_out,
  output logic               line_done_out
);

  localparam logic [4:0] c_LAST_COL  = 5'(TILES_PER_LINE - 1);
  localparam logic [4:0] c_FIFO_ROOM = 5'd8;

  fetch_state_e r_state;
  logic [4:0]   r_col;
  logic [7:0]   r_y;
  logic [4:0]   r_tx0;
  logic         r_map_sel;
  logic         r_data_sel;
  logic [3:0]   r_attr;
  logic [7:0]   r_lo;
  logic [2:0]   r_pix_idx;

  logic [7:0]         w_y_start;
  logic [4:0]         w_col_next;
  logic [4:0]         w_tx_next;
  logic               w_hi_load;
  logic               w_shift;
  logic [PIXEL_W-1:0] w_pixel;
  logic               w_unused_fine_scx;

  function automatic logic [12:0] f_map_addr(input logic sel, input logic [7:0] y,
                                             input logic [4:0] tx);
    return (sel ? MAP_BASE_1 : MAP_BASE_0) + {3'b000, y[7:3], tx};
  endfunction

  // Unsigned mode indexes from 0x0000; signed mode centres tile 0 at 0x1000.
  function automatic logic [12:0] f_lo_addr(input logic unsigned_mode, input logic [7:0] idx,
                                            input logic [7:0] y);
    logic [12:0] tile_base;
    tile_base = unsigned_mode ? {1'b0, idx, 4'h0} : SIGNED_BASE + {idx[7], idx, 4'h0};
    return tile_base + {9'd0, y[2:0], 1'b0};
  endfunction

  assign w_y_start         = line_in + scy_in;
  assign w_col_next        = r_col + 5'd1;
  assign w_tx_next         = r_tx0 + w_col_next;
  assign w_hi_load         = (r_state == HI_REQ) && vram_ack_in;
  assign w_shift           = ((r_state == PUSH_WAIT) && (fifo_count_in <= c_FIFO_ROOM)) ||
                             ((r_state == PUSH) && (r_pix_idx != 3'd7));
  assign w_unused_fine_scx = ^scx_in[2:0];

  tile_shifter u_shifter (
    .clk     (clk_in),
    .rst     (rst_in),
    .i_load  (w_hi_load),
    .i_lo    (r_lo),
    .i_hi    (vram_data_in),
    .i_attr  (r_attr),
    .i_shift (w_shift),
    .o_pixel (w_pixel)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= IDLE;
      r_col          <= '0;
      r_y            <= '0;
      r_tx0          <= '0;
      r_map_sel      <= 1'b0;
      r_data_sel     <= 1'b0;
      r_attr         <= '0;
      r_lo           <= '0;
      r_pix_idx      <= '0;
      vram_req_out   <= 1'b0;
      vram_addr_out  <= '0;
      fifo_wr_en_out <= 1'b0;
      fifo_pixel_out <= '0;
      busy_out       <= 1'b0;
      line_done_out  <= 1'b0;
    end else begin
      line_done_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_in) begin
            r_y           <= w_y_start;
            r_tx0         <= scx_in[7:3];
            r_map_sel     <= map_sel_in;
            r_data_sel    <= data_sel_in;
            r_attr        <= attr_in;
            r_col         <= '0;
            busy_out      <= 1'b1;
            vram_req_out  <= 1'b1;
            vram_addr_out <= f_map_addr(map_sel_in, w_y_start, scx_in[7:3]);
            r_state       <= MAP_REQ;
          end
        end
        MAP_REQ: begin
          if (vram_ack_in) begin
            vram_addr_out <= f_lo_addr(r_data_sel, vram_data_in, r_y);
            r_state       <= LO_REQ;
          end
        end
        LO_REQ: begin
          if (vram_ack_in) begin
            r_lo          <= vram_data_in;
            vram_addr_out <= vram_addr_out + 13'd1;
            r_state       <= HI_REQ;
          end
        end
        HI_REQ: begin
          if (vram_ack_in) begin
            vram_req_out  <= 1'b0;
            vram_addr_out <= '0;
            r_state       <= PUSH_WAIT;
          end
        end
        PUSH_WAIT: begin
          if (fifo_count_in <= c_FIFO_ROOM) begin
            fifo_wr_en_out <= 1'b1;
            fifo_pixel_out <= w_pixel;
            r_pix_idx      <= '0;
            r_state        <= PUSH;
          end
        end
        PUSH: begin
          if (r_pix_idx != 3'd7) begin
            r_pix_idx      <= r_pix_idx + 3'd1;
            fifo_pixel_out <= w_pixel;
          end else begin
            fifo_wr_en_out <= 1'b0;
            fifo_pixel_out <= '0;
            if (r_col == c_LAST_COL) begin
              r_col         <= '0;
              busy_out      <= 1'b0;
              line_done_out <= 1'b1;
              r_state       <= IDLE;
            end else begin
              r_col         <= w_col_next;
              vram_req_out  <= 1'b1;
              vram_addr_out <= f_map_addr(r_map_sel, r_y, w_tx_next);
              r_state       <= MAP_REQ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
